// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder.
// State encoding and default operand width.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width needed to index WIDTH bits.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_add_bit.sv
// One-bit full-add cell for the serial adder.
// Two half-add stages merged by an OR on the carries.
module serial_add_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  // First half add: operand bits.
  assign w_s1 = a ^ b;
  assign w_c1 = a & b;

  // Second half add: partial sum with incoming carry.
  assign s    = w_s1 ^ cin;
  assign w_c2 = w_s1 & cin;

  // Only one half stage can carry at a time.
  assign cout = w_c1 | w_c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial unsigned adder: one operand bit per clock.
// Result and carry publish on the edge entering DONE.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;

  logic             w_s;
  logic             w_cout;
  logic [WIDTH-1:0] w_acc_nxt;

  serial_add_bit u_bit (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout)
  );

  // New sum bit enters at the top; after WIDTH shifts bit 0 sits at the LSB.
  assign w_acc_nxt = {w_s, r_acc[WIDTH-1:1]};

  // Controller, operand shifters, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE, DONE: begin
          if (clr) begin
            r_state <= IDLE;
          end else if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          if (clr) begin
            r_state <= IDLE;
          end else begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_acc   <= w_acc_nxt;
            r_carry <= w_cout;
            if (r_cnt == LAST) begin
              r_cnt   <= '0;
              r_sum   <= w_acc_nxt;
              r_cout  <= w_cout;
              r_state <= DONE;
            end else begin
              r_cnt   <= r_cnt + CW'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Status flags decode registered state only.
  assign busy      = (r_state == RUN);
  assign done      = (r_state == DONE);
  assign sum       = r_sum;
  assign carry_out = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl, WIDTH=8.
// Vector table, corner sequences and random ops vs a+b.
module tb_serial_add_ctrl;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         clr;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;

  int checks;
  int errors;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clr       (clr),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // One operation; returns latency in cycles after start edge,
  // busy cycle count and the result seen with done.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                       input bit noise, output int lat, output int bcnt,
                       output logic [W-1:0] rs, output logic rc);
    @(negedge clk);
    a = ta; b = tb_; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      if (noise && lat == 3) begin
        start = 1'b1;
        a = W'($urandom); b = W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    rs = sum; rc = carry_out;
  endtask

  task automatic check_op(input string tag, input logic [W-1:0] ta,
                          input logic [W-1:0] tb_, input bit noise);
    int lat, bcnt;
    logic [W-1:0] rs;
    logic rc;
    logic [W:0] ref_full;
    ref_full = {1'b0, ta} + {1'b0, tb_};
    do_op(ta, tb_, noise, lat, bcnt, rs, rc);
    chk({tag, " latency"}, 32'(lat), 32'(W + 1));
    chk({tag, " busy_cycles"}, 32'(bcnt), 32'(W));
    chk({tag, " sum"}, 32'(rs), 32'(ref_full[W-1:0]));
    chk({tag, " carry"}, 32'(rc), 32'(ref_full[W]));
  endtask

  vec_t vecs[7];

  initial begin
    int ndone, t0, t1, lat, bcnt;
    logic [W-1:0] rs;
    logic rc;

    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; clr = 1'b0; a = '0; b = '0;

    vecs[0] = '{a: 8'h00, b: 8'h00, s: 8'h00, c: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, s: 8'h00, c: 1'b1};
    vecs[2] = '{a: 8'hA5, b: 8'h5A, s: 8'hFF, c: 1'b0};
    vecs[3] = '{a: 8'h7F, b: 8'h01, s: 8'h80, c: 1'b0};
    vecs[4] = '{a: 8'hFF, b: 8'hFF, s: 8'hFE, c: 1'b1};
    vecs[5] = '{a: 8'h80, b: 8'h80, s: 8'h00, c: 1'b1};
    vecs[6] = '{a: 8'h03, b: 8'h04, s: 8'h07, c: 1'b0};

    repeat (2) @(negedge clk);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset sum", 32'(sum), 0);
    chk("reset carry", 32'(carry_out), 0);
    chk("reset no_x", 32'($isunknown({busy, done, sum, carry_out})), 0);
    rst_n = 1'b1;

    // Table vectors.
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, 1'b0, lat, bcnt, rs, rc);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(W + 1));
      chk($sformatf("vec%0d busy_cycles", i), 32'(bcnt), 32'(W));
      chk($sformatf("vec%0d sum", i), 32'(rs), 32'(vecs[i].s));
      chk($sformatf("vec%0d carry", i), 32'(rc), 32'(vecs[i].c));
      @(negedge clk);
      chk($sformatf("vec%0d done_pulse", i), 32'(done), 0);
      chk($sformatf("vec%0d hold", i), 32'({carry_out, sum}),
          32'({vecs[i].c, vecs[i].s}));
    end

    // Start pulsed during RUN is ignored; one done only.
    @(negedge clk);
    a = 8'h10; b = 8'h20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'h01; b = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; rs = '0;
    for (int i = 0; i < 25; i++) begin
      if (done) begin ndone++; rs = sum; end
      @(negedge clk);
    end
    chk("ignore_start done_count", 32'(ndone), 1);
    chk("ignore_start sum", 32'(rs), 32'h30);

    // Start held through DONE: back-to-back operations.
    a = 8'h80; b = 8'h80; start = 1'b1;
    ndone = 0; t0 = -1; t1 = -1;
    for (int i = 0; i < 40 && ndone < 2; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if (ndone == 1) t0 = i; else t1 = i;
        chk("b2b sum", 32'(sum), 32'h00);
        chk("b2b carry", 32'(carry_out), 1);
      end
    end
    start = 1'b0;
    chk("b2b done_count", 32'(ndone), 2);
    chk("b2b spacing", 32'(t1 - t0), 9);
    @(negedge clk);
    chk("b2b idle_after", 32'({busy, done}), 0);

    // clr in RUN aborts and keeps the previous result.
    check_op("pre_clr", 8'h03, 8'h04, 1'b0);
    @(negedge clk);
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr busy", 32'(busy), 0);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("clr no_done", 32'(ndone), 0);
    chk("clr sum_kept", 32'(sum), 32'h07);
    chk("clr carry_kept", 32'(carry_out), 0);

    // clr beats start in IDLE.
    a = 8'h11; b = 8'h22; start = 1'b1; clr = 1'b1;
    @(negedge clk);
    start = 1'b0; clr = 1'b0;
    chk("clr_start idle", 32'(busy), 0);

    // Asynchronous reset mid-RUN.
    check_op("pre_rst", 8'hFF, 8'h01, 1'b0);
    @(negedge clk);
    a = 8'h55; b = 8'h66; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst outputs", 32'({busy, done, sum, carry_out}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_op("post_rst", 8'h7F, 8'h01, 1'b0);

    // Random operations, some with stray starts mid-RUN.
    for (int i = 0; i < 30; i++) begin
      check_op($sformatf("rnd%0d", i), W'($urandom), W'($urandom),
               1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request a new addition; sampled on rising edge of clk.
REQ-005 clr  input  1  synchronous abort of an operation in progress.
REQ-006 a  input  WIDTH  operand A; captured only when start is accepted.
REQ-007 b  input  WIDTH  operand B; captured only when start is accepted.
REQ-008 busy  output  1  high while an addition is in progress (state RUN).
REQ-009 done  output  1  one-cycle pulse; sum and carry_out are valid.
REQ-010 sum  output  WIDTH  result, A+B modulo 2^WIDTH.
REQ-011 carry_out  output  1  carry out of bit WIDTH-1.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-013 IDLE: start=1 -> capture a and b into shift registers, clear the carry flop, clear the bit counter, go to RUN.
REQ-014 RUN: each edge SHALL add the operand LSBs and the carry flop in a one-bit full-add cell, shift the sum bit into the result register MSB-first, shift both operands right, update the carry flop, and increment the counter.
REQ-015 RUN -> DONE on the edge that processes bit WIDTH-1; the counter SHALL wrap to 0 at that edge.
REQ-016 DONE lasts exactly one cycle with done=1, then returns to IDLE; start=1 in DONE SHALL be accepted exactly as in IDLE (back-to-back operation).
REQ-017 Latency: if start is sampled at edge k, done SHALL be high in the cycle after edge k+WIDTH.
REQ-018 busy SHALL equal (state==RUN); done SHALL equal (state==DONE); both are registered-state decodes with no input-to-output combinational path.
REQ-019 start while in RUN SHALL be ignored; a, b, and the operation in progress are unaffected.
REQ-020 sum and carry_out SHALL be updated only on the edge entering DONE, and SHALL hold until the next completed operation.
REQ-021 clr=1 in RUN SHALL force IDLE on the next edge without asserting done; sum and carry_out keep their previous values.
REQ-022 clr=1 together with start in IDLE or DONE: clr wins, state goes to or stays in IDLE, and the operands are not captured.
REQ-023 Arithmetic SHALL be unsigned; {carry_out,sum} SHALL equal a+b exactly for all operand values.

Reset
REQ-024 rst_n=0 SHALL immediately force: state IDLE, busy 0, done 0, sum 0, carry_out 0, carry flop 0, counter 0, operand registers 0.
REQ-025 Reset asserted mid-RUN SHALL abort the operation without a done pulse; after release the block SHALL accept start on the first edge.
REQ-026 No output SHALL be X after reset is asserted.

Structure
REQ-027 A shared package serial_add_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default width constant.
REQ-028 The counter width SHALL be $clog2(WIDTH).
REQ-029 The one-bit full-add cell SHALL be a sub-module, serial_add_bit (inputs a, b, cin; outputs s, cout), built from two half-add stages plus an OR.
REQ-030 The FSM, counter, and shift registers SHALL reside in serial_add_ctrl.

Verification (WIDTH=8)
REQ-031 a=0x00, b=0x00, start pulse at edge k -> busy high for 8 cycles; done in the cycle after edge k+8; sum=0x00; carry_out=0.
REQ-032 a=0xFF, b=0x01 -> sum=0x00, carry_out=1; a=0xA5, b=0x5A -> sum=0xFF, carry_out=0.
REQ-033 Start a=0x10, b=0x20; pulse start again with a=0x01, b=0x01 during RUN -> result is sum=0x30, and only one done pulse occurs.
REQ-034 Start held high through DONE with a=0x80, b=0x80 -> second operation begins with no idle cycle; results are 0x00/carry 1, then 0x00/carry 1 again; two done pulses 9 cycles apart.
REQ-035 Complete 0x03+0x04, then start 0xFF+0xFF and apply clr at the 4th RUN cycle -> no done; sum=0x07 and carry_out=0 retained; state IDLE.
REQ-036 rst_n low mid-RUN -> all outputs 0 immediately; after release, 0x7F+0x01 -> sum=0x80, carry_out=0.
